// File: rtl/led_owner_sched.sv
`default_nettype none
// ============================================================================
// Module   : led_owner_sched
// Purpose  : Owns the single board LED and shares it between HPS software
//            (PIO value + request line) and a local blink generator selected
//            by the board switch. The switch is synchronised and debounced,
//            the switch has fixed priority over HPS, and a watchdog revokes
//            HPS ownership when the PIO value stops toggling.
// Ports    : clk_clk       in  system clock
//            reset_reset   in  asynchronous active-high reset
//            switch_export in  raw switch pin (asynchronous to clk_clk)
//            hps_req       in  HPS level request for LED ownership
//            pio_led       in  LED value from the PIO conduit
//            led_out       out LED pin drive (registered)
//            hps_gnt       out HPS currently owns the LED (registered)
//            switch_db     out debounced switch level (registered)
//            state         out 00 IDLE, 01 HPS, 10 BLINK, 11 FAULT
// Revision : 1.0  initial release
// ============================================================================
module led_owner_sched #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned BLINK_HALF      = 25000000,
    parameter int unsigned HPS_TIMEOUT     = 50000000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       switch_export,
    input  logic       hps_req,
    input  logic       pio_led,
    output logic       led_out,
    output logic       hps_gnt,
    output logic       switch_db,
    output logic [1:0] state
);

    localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_BLINK_LAST = CNT_W'(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] C_WD_LAST    = CNT_W'(HPS_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HPS   = 2'b01,
        ST_BLINK = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Switch synchroniser and PIO history
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic pio_prev_q;
    logic pio_edge;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            pio_prev_q <= 1'b0;
        end else begin
            sync1_q    <= switch_export;
            sync2_q    <= sync1_q;
            pio_prev_q <= pio_led;
        end
    end

    // Any change of pio_led relative to the previous cycle counts as activity.
    assign pio_edge = pio_led ^ pio_prev_q;

    // ------------------------------------------------------------------
    // Debouncer: switch_db follows sw_s only after it has differed for
    // DEBOUNCE_CYCLES consecutive cycles.
    // ------------------------------------------------------------------
    logic             switch_db_q;
    logic             switch_db_d;
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] db_cnt_d;

    always_comb begin
        switch_db_d = switch_db_q;
        db_cnt_d    = '0;
        if (sync2_q != switch_db_q) begin
            if (db_cnt_q == C_DB_LAST) begin
                switch_db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + C_ONE;
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            switch_db_q <= 1'b0;
            db_cnt_q    <= '0;
        end else begin
            switch_db_q <= switch_db_d;
            db_cnt_q    <= db_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Ownership FSM with registered outputs, blink counter and watchdog
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic             led_q;
    logic             led_d;
    logic             gnt_q;
    logic             gnt_d;
    logic [CNT_W-1:0] blink_cnt_q;
    logic [CNT_W-1:0] blink_cnt_d;
    logic [CNT_W-1:0] wd_q;
    logic [CNT_W-1:0] wd_d;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= ST_IDLE;
            led_q       <= 1'b0;
            gnt_q       <= 1'b0;
            blink_cnt_q <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            gnt_q       <= gnt_d;
            blink_cnt_q <= blink_cnt_d;
            wd_q        <= wd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        led_d       = 1'b0;
        gnt_d       = 1'b0;
        blink_cnt_d = '0;
        wd_d        = '0;

        // Transitions, first match wins.
        unique case (state_q)
            ST_IDLE: begin
                if (switch_db_q)   state_d = ST_BLINK;
                else if (hps_req)  state_d = ST_HPS;
            end
            ST_HPS: begin
                if (switch_db_q)   state_d = ST_BLINK;
                else if (!hps_req) state_d = ST_IDLE;
                // A coincident PIO edge rescues the grant at expiry.
                else if ((wd_q == C_WD_LAST) && !pio_edge) state_d = ST_FAULT;
            end
            ST_BLINK: begin
                if (!switch_db_q)  state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (switch_db_q)   state_d = ST_BLINK;
                else if (!hps_req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are computed for the state being entered so they change on
        // the same edge as the state register.
        unique case (state_d)
            ST_HPS: begin
                gnt_d = 1'b1;
                led_d = pio_led;
                if ((state_q == ST_HPS) && !pio_edge) begin
                    wd_d = wd_q + C_ONE;
                end
            end
            ST_BLINK: begin
                if (state_q != ST_BLINK) begin
                    led_d = 1'b1;
                end else if (blink_cnt_q == C_BLINK_LAST) begin
                    led_d = ~led_q;
                end else begin
                    led_d       = led_q;
                    blink_cnt_d = blink_cnt_q + C_ONE;
                end
            end
            default: begin
                led_d = 1'b0;
            end
        endcase
    end

    assign led_out   = led_q;
    assign hps_gnt   = gnt_q;
    assign switch_db = switch_db_q;
    assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_led_owner_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_owner_sched
// Purpose  : Self-checking bench for led_owner_sched. Directed scenarios for
//            each ownership rule followed by randomized traffic, all checked
//            every cycle against a cycle-level behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_led_owner_sched;

    localparam int DB = 4;
    localparam int BH = 3;
    localparam int TO = 10;

    localparam int M_IDLE  = 0;
    localparam int M_HPS   = 1;
    localparam int M_BLINK = 2;
    localparam int M_FAULT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw;
    logic       req;
    logic       pio;
    logic       led;
    logic       gnt;
    logic       db;
    logic [1:0] st;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    led_owner_sched #(
        .DEBOUNCE_CYCLES (DB),
        .BLINK_HALF      (BH),
        .HPS_TIMEOUT     (TO),
        .CNT_W           (32)
    ) u_dut (
        .clk_clk       (clk),
        .reset_reset   (rst),
        .switch_export (sw),
        .hps_req       (req),
        .pio_led       (pio),
        .led_out       (led),
        .hps_gnt       (gnt),
        .switch_db     (db),
        .state         (st)
    );

    // Reference model state
    int m_pin_d1, m_pin_d2;   // pin delayed by one and two cycles
    int m_db, m_run;          // debounced level, cycles the synced pin has disagreed
    int m_st, m_led, m_gnt;
    int m_age;                // cycles spent in BLINK since entry
    int m_idle_pio;           // cycles in HPS since last PIO activity or entry
    int m_pio_last;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pin_d1 = 0; m_pin_d2 = 0; m_db = 0; m_run = 0;
        m_st = M_IDLE; m_led = 0; m_gnt = 0; m_age = 0;
        m_idle_pio = 0; m_pio_last = 0;
    endtask

    // One rising edge: every next value is derived from pre-edge values.
    task automatic model_step();
        int n_db, n_run, n_st;
        bit activity;
        n_db  = m_db;
        n_run = 0;
        if (m_pin_d2 != m_db) begin
            if (m_run + 1 >= DB) n_db = m_pin_d2;
            else                 n_run = m_run + 1;
        end
        activity = (int'(pio) != m_pio_last);

        n_st = m_st;
        case (m_st)
            M_IDLE:  n_st = m_db ? M_BLINK : (req ? M_HPS : M_IDLE);
            M_HPS: begin
                if (m_db)                                  n_st = M_BLINK;
                else if (!req)                             n_st = M_IDLE;
                else if (m_idle_pio + 1 >= TO && !activity) n_st = M_FAULT;
            end
            M_BLINK: n_st = m_db ? M_BLINK : M_IDLE;
            default: n_st = m_db ? M_BLINK : (req ? M_FAULT : M_IDLE);
        endcase

        m_gnt = (n_st == M_HPS);
        if (n_st == M_HPS) begin
            m_led = int'(pio);
            m_idle_pio = (m_st == M_HPS && !activity) ? m_idle_pio + 1 : 0;
        end else begin
            m_idle_pio = 0;
        end
        if (n_st == M_BLINK) begin
            m_age = (m_st == M_BLINK) ? m_age + 1 : 0;
            m_led = ((m_age / BH) % 2 == 0) ? 1 : 0;
        end else if (n_st != M_HPS) begin
            m_led = 0;
        end

        m_st       = n_st;
        m_db       = n_db;
        m_run      = n_run;
        m_pin_d2   = m_pin_d1;
        m_pin_d1   = int'(sw);
        m_pio_last = int'(pio);
    endtask

    task automatic check_all();
        chk("led_out",   int'(led), m_led);
        chk("hps_gnt",   int'(gnt), m_gnt);
        chk("switch_db", int'(db),  m_db);
        chk("state",     int'(st),  m_st);
    endtask

    // Advance one clock; inputs are only changed 1 ns after an edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset pulse between edges, checked before the next edge.
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int mode;
        rst = 1'b1; sw = 1'b0; req = 1'b0; pio = 1'b0;
        model_reset();
        #12;
        check_all();
        tick();
        rst = 1'b0;

        // HPS ownership with regular PIO activity: no watchdog expiry.
        req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i % 5 == 4) pio = ~pio;
        end

        // Short glitch is rejected, held level debounces, then blink.
        sw = 1'b1; ticks(3);
        sw = 1'b0; ticks(8);
        sw = 1'b1; ticks(20);
        sw = 1'b0; ticks(10);

        // Watchdog expiry, FAULT holds until request drops, then regain.
        ticks(16);
        req = 1'b0; ticks(2);
        req = 1'b1; ticks(4);

        // Switch debounce landing around the watchdog expiry cycle.
        for (int off = 0; off < 10; off++) begin
            pulse_reset();
            req = 1'b1; tick();
            ticks(off);
            sw = 1'b1; ticks(14);
            sw = 1'b0; ticks(8);
        end

        // Reset mid-BLINK must clear outputs immediately.
        sw = 1'b1; ticks(12);
        pulse_reset();
        sw = 1'b0; ticks(3);

        // Randomized traffic with varying PIO activity rates.
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 60 == 0) mode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 39) == 0) req = ~req;
            if ($urandom_range(0, 24) == 0) sw = ~sw;
            if (mode == 0 && $urandom_range(0, 2) == 0) pio = ~pio;
            if (mode == 1 && $urandom_range(0, 10) == 0) pio = ~pio;
            if ($urandom_range(0, 499) == 0) pulse_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
